apb_arbiter2: RTL and testbench

//  Shares one APB completer bus (5-bit address, 8-bit data) between two APB requesters,
//  e.g. two stream-to-APB bridges on different host interfaces. Re-times each transfer

---
 rtl/apb_arbiter2_pkg.sv | 30 +++
 rtl/apb_arbiter2_watchdog.sv | 41 ++++
 rtl/apb_arbiter2.sv | 227 ++++++++++++++++++++++
 tb/tb_apb_arbiter2.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arbiter2_pkg.sv
// Shared definitions for the two-requester APB arbiter: default bus widths,
// FSM state encodings and small helpers used by the arbiter and its watchdog.
package apb_arbiter2_pkg;

  // Default shared-bus geometry
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;

  // Shared-bus transfer FSM encodings (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // Read value returned to a requester whose transfer was aborted (8-bit bus)
  localparam logic [7:0] ABORT_RDATA = 8'hFF;

  // Requester index to one-hot grant vector
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // Round-robin pick between two eligible requesters.
  // With both eligible the one not served last wins; otherwise the sole one.
  function automatic logic rr_pick(input logic [1:0] elig, input logic last_id);
    return (elig == 2'b11) ? ~last_id : elig[1];
  endfunction

endpackage

// File: rtl/apb_arbiter2_watchdog.sv
// ACCESS-phase stall watchdog. Counts consecutive stalled ACCESS cycles and flags
// expiry on the cycle that would make the count reach TIMEOUT, so the caller can
// abort at the end of exactly TIMEOUT stalled cycles. TIMEOUT of 0 disables it.
module apb_arbiter2_watchdog #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic clear_i,   // restart count (entering ACCESS)
  input  logic stall_i,   // in ACCESS with PREADY low
  output logic expired_o  // this stalled cycle is the TIMEOUT-th one
);

  localparam bit Enabled = (TIMEOUT != 0);
  // Expiry is detected on the last stalled cycle, i.e. while the count is TIMEOUT-1
  localparam logic [TIMEOUT_W-1:0] Limit = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Expiry flag and counter next-state
  always_comb begin
    expired_o = Enabled && stall_i && (cnt_q == Limit);
    cnt_d     = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (Enabled && stall_i && !expired_o) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_arbiter2.sv
// Two-requester APB arbiter. Each requester transfer is re-timed onto one shared
// completer bus through IDLE -> SETUP -> ACCESS -> RESP. Round-robin between
// requesters, a per-requester lock that keeps the bus with its owner across
// transfers, and a watchdog that aborts transfers stalled on PREADY.
module apb_arbiter2
  import apb_arbiter2_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  // Requester 0
  input  logic              m0_lock_i,
  input  logic              m0_PSEL_i,
  input  logic              m0_PENABLE_i,
  input  logic              m0_PWRITE_i,
  input  logic [ADDR_W-1:0] m0_PADDR_i,
  input  logic [DATA_W-1:0] m0_PWDATA_i,
  output logic [DATA_W-1:0] m0_PRDATA_o,
  output logic              m0_PREADY_o,
  // Requester 1
  input  logic              m1_lock_i,
  input  logic              m1_PSEL_i,
  input  logic              m1_PENABLE_i,
  input  logic              m1_PWRITE_i,
  input  logic [ADDR_W-1:0] m1_PADDR_i,
  input  logic [DATA_W-1:0] m1_PWDATA_i,
  output logic [DATA_W-1:0] m1_PRDATA_o,
  output logic              m1_PREADY_o,
  // Shared completer bus
  output logic              PSEL_o,
  output logic              PENABLE_o,
  output logic              PWRITE_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  input  logic [DATA_W-1:0] PRDATA_i,
  input  logic              PREADY_i,
  // Status
  output logic [1:0]        grant_o,
  output logic              timeout_err_o,
  input  logic              err_clear_i
);

  state_t            st_q, st_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              id_q, id_d;            // requester owning the current transfer
  logic              last_q, last_d;        // requester served most recently
  logic              lock_vld_q, lock_vld_d;
  logic              lock_id_q, lock_id_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        resp_q, resp_d;        // one-hot completion pulse
  logic              err_q, err_d;

  logic [1:0]        req;
  logic [1:0]        lock_in;
  logic [1:0]        elig;
  logic              owner_locked;
  logic              win_id;
  logic              err_set;
  logic              wd_clear;
  logic              wd_stall;
  logic              wd_expired;

  // PENABLE from the requesters carries no information the arbiter needs
  logic              unused_penable;
  assign unused_penable = m0_PENABLE_i ^ m1_PENABLE_i;

  // Eligibility: a locked owner masks out the other requester
  always_comb begin
    req          = {m1_PSEL_i, m0_PSEL_i};
    lock_in      = {m1_lock_i, m0_lock_i};
    owner_locked = lock_vld_q & lock_in[lock_id_q];
    elig         = owner_locked ? (req & id_onehot(lock_id_q)) : req;
    win_id       = rr_pick(elig, last_q);
  end

  assign wd_clear = (st_q == ST_SETUP);
  assign wd_stall = (st_q == ST_ACCESS) & ~PREADY_i;

  apb_arbiter2_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .clear_i   (wd_clear),
    .stall_i   (wd_stall),
    .expired_o (wd_expired)
  );

  // Transfer FSM, arbitration, lock ownership and error flag next-state
  always_comb begin
    st_d       = st_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rdata_d    = rdata_q;
    id_d       = id_q;
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    grant_d    = grant_q;
    resp_d     = 2'b00;
    err_set    = 1'b0;

    unique case (st_q)
      ST_IDLE: begin
        // Ownership lapses in the first IDLE cycle where the owner's lock is low
        lock_vld_d = owner_locked;
        grant_d    = owner_locked ? id_onehot(lock_id_q) : 2'b00;
        if (elig != 2'b00) begin
          id_d      = win_id;
          last_d    = win_id;
          grant_d   = id_onehot(win_id);
          pwrite_d  = win_id ? m1_PWRITE_i : m0_PWRITE_i;
          paddr_d   = win_id ? m1_PADDR_i  : m0_PADDR_i;
          pwdata_d  = win_id ? m1_PWDATA_i : m0_PWDATA_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          st_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        st_d      = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY_i) begin
          rdata_d   = PRDATA_i;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          resp_d    = id_onehot(id_q);
          st_d      = ST_RESP;
        end else if (wd_expired) begin
          // Abort: release the bus and hand the requester an all-ones read value
          rdata_d   = (DATA_W == 8) ? DATA_W'(ABORT_RDATA) : '1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          resp_d    = id_onehot(id_q);
          err_set   = 1'b1;
          st_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        // A transfer made with lock high makes its requester the owner
        if (lock_in[id_q]) begin
          lock_vld_d = 1'b1;
          lock_id_d  = id_q;
        end else if (!lock_vld_q) begin
          grant_d = 2'b00;
        end
        st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase

    // A new abort outranks a same-cycle clear
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; reset favours m0 by marking m1 as last served
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      st_q       <= ST_IDLE;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rdata_q    <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
      grant_q    <= 2'b00;
      resp_q     <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rdata_q    <= rdata_d;
      id_q       <= id_d;
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      grant_q    <= grant_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
    end
  end

  // Shared bus driven straight from registers: no combinational path from requesters
  assign PSEL_o        = psel_q;
  assign PENABLE_o     = penable_q;
  assign PWRITE_o      = pwrite_q;
  assign PADDR_o       = paddr_q;
  assign PWDATA_o      = pwdata_q;
  assign grant_o       = grant_q;
  assign timeout_err_o = err_q;

  // Read data only presented alongside the owning requester's pulse
  assign m0_PREADY_o = resp_q[0];
  assign m1_PREADY_o = resp_q[1];
  assign m0_PRDATA_o = resp_q[0] ? rdata_q : '0;
  assign m1_PRDATA_o = resp_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_apb_arbiter2.sv
// Bench for apb_arbiter2: scenario tasks drive the two requesters and a simple
// completer; expected responses go into a scoreboard queue that is drained as
// mN_PREADY pulses appear.
module tb_apb_arbiter2;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       m0_lock = 0, m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
  logic [4:0] m0_paddr = '0;
  logic [7:0] m0_pwdata = '0;
  logic       m1_lock = 0, m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
  logic [4:0] m1_paddr = '0;
  logic [7:0] m1_pwdata = '0;
  logic [7:0] m0_PRDATA_o, m1_PRDATA_o, PWDATA_o;
  logic       m0_PREADY_o, m1_PREADY_o, PSEL_o, PENABLE_o, PWRITE_o, timeout_err_o;
  logic [4:0] PADDR_o;
  logic [1:0] grant_o;
  logic [7:0] prdata_v = '0;
  logic       pready_v = 1'b1;
  logic       err_clear = 1'b0;

  apb_arbiter2 #(
    .ADDR_W    (5),
    .DATA_W    (8),
    .TIMEOUT   (4),
    .TIMEOUT_W (8)
  ) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .m0_lock_i     (m0_lock),
    .m0_PSEL_i     (m0_psel),
    .m0_PENABLE_i  (m0_penable),
    .m0_PWRITE_i   (m0_pwrite),
    .m0_PADDR_i    (m0_paddr),
    .m0_PWDATA_i   (m0_pwdata),
    .m0_PRDATA_o   (m0_PRDATA_o),
    .m0_PREADY_o   (m0_PREADY_o),
    .m1_lock_i     (m1_lock),
    .m1_PSEL_i     (m1_psel),
    .m1_PENABLE_i  (m1_penable),
    .m1_PWRITE_i   (m1_pwrite),
    .m1_PADDR_i    (m1_paddr),
    .m1_PWDATA_i   (m1_pwdata),
    .m1_PRDATA_o   (m1_PRDATA_o),
    .m1_PREADY_o   (m1_PREADY_o),
    .PSEL_o        (PSEL_o),
    .PENABLE_o     (PENABLE_o),
    .PWRITE_o      (PWRITE_o),
    .PADDR_o       (PADDR_o),
    .PWDATA_o      (PWDATA_o),
    .PRDATA_i      (prdata_v),
    .PREADY_i      (pready_v),
    .grant_o       (grant_o),
    .timeout_err_o (timeout_err_o),
    .err_clear_i   (err_clear)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [36:0] outs;
  assign outs = {PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, grant_o, timeout_err_o,
                 m0_PREADY_o, m1_PREADY_o, m0_PRDATA_o, m1_PRDATA_o};

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pend0 = 0, pend1 = 0;
  int   pulse_cyc0 = 0, pulse_cyc1 = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance to the next falling edge and retire any completion pulse against the scoreboard
  task automatic nclk();
    exp_t e;
    logic got_id;
    logic [7:0] got_d;
    @(negedge CLK);
    if (m0_PREADY_o || m1_PREADY_o) begin
      checks++;
      got_id = m1_PREADY_o;
      got_d  = got_id ? m1_PRDATA_o : m0_PRDATA_o;
      if (m0_PREADY_o && m1_PREADY_o) begin
        errors++;
        $display("FAIL resp_both: m0_PREADY=1 m1_PREADY=1 required one at a time");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: pulse on m%0d data=%h, none required", got_id, got_d);
      end else begin
        e = sb.pop_front();
        if (got_id !== e.id || got_d !== e.data) begin
          errors++;
          $display("FAIL resp_order: got m%0d data=%h required m%0d data=%h",
                   got_id, got_d, e.id, e.data);
        end
      end
      if (m0_PREADY_o) pulse_cyc0 = cyc;
      if (m1_PREADY_o) pulse_cyc1 = cyc;
    end
  endtask

  // One cycle of requester behaviour: on its pulse a requester issues its next
  // transfer immediately or drops PSEL (and its lock) when it has none left
  task automatic step();
    logic r0, r1;
    nclk();
    r0 = m0_PREADY_o;
    r1 = m1_PREADY_o;
    tick();
    if (r0 && pend0 > 0) begin
      pend0--;
      if (pend0 > 0) begin
        m0_paddr  = m0_paddr + 5'd1;
        m0_pwdata = m0_pwdata + 8'd1;
      end else begin
        m0_psel = 0;
        m0_penable = 0;
        m0_lock = 0;
      end
    end
    if (r1 && pend1 > 0) begin
      pend1--;
      if (pend1 > 0) begin
        m1_paddr  = m1_paddr + 5'd1;
        m1_pwdata = m1_pwdata + 8'd1;
      end else begin
        m1_psel = 0;
        m1_penable = 0;
        m1_lock = 0;
      end
    end
  endtask

  task automatic run_requesters(input int budget);
    for (int i = 0; i < budget && (pend0 > 0 || pend1 > 0); i++) step();
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) nclk();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    RESETn = 0;
    repeat (2) tick();
    RESETn = 1;
  endtask

  task automatic test_reset();
    RESETn = 0;
    m0_psel = 1;
    m0_paddr = 5'h07;
    m1_psel = 1;
    repeat (3) tick();
    nclk();
    checks++;
    if (outs !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    m0_psel = 0;
    m1_psel = 0;
    m0_paddr = '0;
    tick();
    RESETn = 1;
    nclk();
    checks++;
    if (grant_o !== 2'b00 || PSEL_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: grant=%b PSEL=%b required 00/0", grant_o, PSEL_o);
    end
  endtask

  task automatic test_single_write();
    tick();
    prdata_v = 8'h11;
    pready_v = 1;
    sb.push_back(exp_t'{1'b0, 8'h11});
    m0_psel = 1; m0_penable = 1; m0_pwrite = 1; m0_paddr = 5'h05; m0_pwdata = 8'hA5;
    nclk();
    checks++;
    if (PSEL_o !== 1'b0) begin
      errors++;
      $display("FAIL write_t0_psel: got %b required 0", PSEL_o);
    end
    nclk();
    checks++;
    if ({PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, grant_o} !== {3'b101, 5'h05, 8'hA5, 2'b01}) begin
      errors++;
      $display("FAIL write_setup: got sel=%b en=%b wr=%b addr=%h wdata=%h grant=%b required 1 0 1 05 a5 01",
               PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, grant_o);
    end
    nclk();
    checks++;
    if (PSEL_o !== 1'b1 || PENABLE_o !== 1'b1) begin
      errors++;
      $display("FAIL write_access: got sel=%b en=%b required 1 1", PSEL_o, PENABLE_o);
    end
    nclk();
    checks++;
    if (m0_PREADY_o !== 1'b1 || m1_PREADY_o !== 1'b0 || PSEL_o !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: got m0_rdy=%b m1_rdy=%b sel=%b required 1 0 0",
               m0_PREADY_o, m1_PREADY_o, PSEL_o);
    end
    tick();
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0;
    nclk();
    checks++;
    if (grant_o !== 2'b00 || m0_PREADY_o !== 1'b0) begin
      errors++;
      $display("FAIL write_after: got grant=%b m0_rdy=%b required 00 0", grant_o, m0_PREADY_o);
    end
    wait_drain("write", 4);
  endtask

  task automatic test_round_robin();
    apply_reset();
    prdata_v = 8'h3C;
    sb.push_back(exp_t'{1'b0, 8'h3C});
    sb.push_back(exp_t'{1'b1, 8'h3C});
    sb.push_back(exp_t'{1'b0, 8'h3C});
    sb.push_back(exp_t'{1'b1, 8'h3C});
    m0_psel = 1; m0_penable = 1; m0_pwrite = 0; m0_paddr = 5'h01;
    m1_psel = 1; m1_penable = 1; m1_pwrite = 0; m1_paddr = 5'h02;
    pend0 = 2;
    pend1 = 2;
    run_requesters(40);
    wait_drain("rr", 8);
    checks++;
    if (pulse_cyc1 - pulse_cyc0 !== 4) begin
      errors++;
      $display("FAIL rr_back_to_back: got spacing %0d required 4", pulse_cyc1 - pulse_cyc0);
    end
  endtask

  task automatic test_lock();
    m1_lock = 1;
    tick();
    nclk();
    checks++;
    if (grant_o !== 2'b00) begin
      errors++;
      $display("FAIL lock_no_transfer: got grant=%b required 00", grant_o);
    end
    tick();
    prdata_v = 8'h42;
    sb.push_back(exp_t'{1'b1, 8'h42});
    sb.push_back(exp_t'{1'b1, 8'h42});
    sb.push_back(exp_t'{1'b1, 8'h42});
    sb.push_back(exp_t'{1'b0, 8'h42});
    m1_psel = 1; m1_penable = 1; m1_pwrite = 1; m1_paddr = 5'h10; m1_pwdata = 8'h90;
    pend1 = 3;
    step();
    m0_psel = 1; m0_penable = 1; m0_pwrite = 0; m0_paddr = 5'h08;
    pend0 = 1;
    run_requesters(40);
    wait_drain("lock", 8);
    checks++;
    if (pulse_cyc0 - pulse_cyc1 !== 4) begin
      errors++;
      $display("FAIL lock_release: m0 served %0d cycles after m1, required 4",
               pulse_cyc0 - pulse_cyc1);
    end
    nclk();
    checks++;
    if (grant_o !== 2'b00) begin
      errors++;
      $display("FAIL lock_grant_idle: got grant=%b required 00", grant_o);
    end
  endtask

  task automatic test_wait_states();
    tick();
    pready_v = 0;
    prdata_v = 8'h5A;
    sb.push_back(exp_t'{1'b0, 8'h5A});
    m0_psel = 1; m0_penable = 1; m0_pwrite = 0; m0_paddr = 5'h0A;
    nclk();
    nclk();
    for (int k = 0; k < 4; k++) begin
      nclk();
      checks++;
      if (PSEL_o !== 1'b1 || PENABLE_o !== 1'b1 || m0_PREADY_o !== 1'b0) begin
        errors++;
        $display("FAIL wait_access%0d: got sel=%b en=%b rdy=%b required 1 1 0",
                 k, PSEL_o, PENABLE_o, m0_PREADY_o);
      end
      if (k == 2) begin
        tick();
        pready_v = 1;
      end
    end
    nclk();
    checks++;
    if (m0_PREADY_o !== 1'b1 || m0_PRDATA_o !== 8'h5A || timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_resp: got rdy=%b data=%h err=%b required 1 5a 0",
               m0_PREADY_o, m0_PRDATA_o, timeout_err_o);
    end
    tick();
    m0_psel = 0; m0_penable = 0;
    wait_drain("wait", 4);
  endtask

  task automatic test_timeout();
    pready_v = 0;
    prdata_v = 8'h12;
    sb.push_back(exp_t'{1'b0, 8'hFF});
    m0_psel = 1; m0_penable = 1; m0_pwrite = 0; m0_paddr = 5'h03;
    nclk();
    nclk();
    for (int k = 0; k < 4; k++) begin
      nclk();
      checks++;
      if (PSEL_o !== 1'b1 || PENABLE_o !== 1'b1) begin
        errors++;
        $display("FAIL timeout_access%0d: got sel=%b en=%b required 1 1", k, PSEL_o, PENABLE_o);
      end
    end
    nclk();
    checks++;
    if (PSEL_o !== 1'b0 || PENABLE_o !== 1'b0 || m0_PREADY_o !== 1'b1 ||
        m0_PRDATA_o !== 8'hFF || timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: got sel=%b en=%b rdy=%b data=%h err=%b required 0 0 1 ff 1",
               PSEL_o, PENABLE_o, m0_PREADY_o, m0_PRDATA_o, timeout_err_o);
    end
    tick();
    m0_psel = 0; m0_penable = 0;
    tick();
    tick();
    nclk();
    checks++;
    if (timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b required 1", timeout_err_o);
    end
    tick();
    err_clear = 1;
    tick();
    err_clear = 0;
    nclk();
    checks++;
    if (timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got err=%b required 0", timeout_err_o);
    end
    pready_v = 1;
    prdata_v = 8'h77;
    tick();
    sb.push_back(exp_t'{1'b1, 8'h77});
    m1_psel = 1; m1_penable = 1; m1_pwrite = 0; m1_paddr = 5'h04;
    pend1 = 1;
    run_requesters(12);
    wait_drain("timeout_next", 4);
    checks++;
    if (timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next_err: got err=%b required 0", timeout_err_o);
    end
  endtask

  task automatic test_reset_mid_transfer();
    tick();
    pready_v = 0;
    m0_psel = 1; m0_penable = 1; m0_pwrite = 1; m0_paddr = 5'h1F; m0_pwdata = 8'hC3;
    tick();
    tick();
    RESETn = 0;
    nclk();
    checks++;
    if (PSEL_o !== 1'b1 || PENABLE_o !== 1'b1 || PADDR_o !== 5'h1F) begin
      errors++;
      $display("FAIL rstmid_access: got sel=%b en=%b addr=%h required 1 1 1f",
               PSEL_o, PENABLE_o, PADDR_o);
    end
    nclk();
    checks++;
    if (outs !== 37'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h required 0", outs);
    end
    tick();
    RESETn = 1;
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0;
    pready_v = 1;
    prdata_v = 8'h66;
    sb.push_back(exp_t'{1'b1, 8'h66});
    m1_psel = 1; m1_penable = 1; m1_pwrite = 0; m1_paddr = 5'h06;
    pend1 = 1;
    nclk();
    nclk();
    checks++;
    if (grant_o !== 2'b10 || PSEL_o !== 1'b1 || PADDR_o !== 5'h06) begin
      errors++;
      $display("FAIL rstmid_fresh: got grant=%b sel=%b addr=%h required 10 1 06",
               grant_o, PSEL_o, PADDR_o);
    end
    run_requesters(12);
    wait_drain("rstmid", 4);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_wait_states();
    test_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1);
  end

endmodule
